// File: rtl/bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_if
//   Bundles the two master request/response channels and the shared Bridge
//   slave bus seen by bus_arbiter.
//   Parameters: ADDR_W (address width), DATA_W (data width).
//   Per master x in {0,1}:
//     mx_req, mx_lock, mx_addr, mx_we, mx_wdata  : requester -> arbiter
//     mx_gnt, mx_rvalid, mx_rdata                : arbiter -> requester
//   Bridge side:
//     s_addr, s_we, s_wdata                      : arbiter -> Bridge
//     s_rdata                                    : Bridge -> arbiter (comb.)
//   Modports:
//     slave  : the arbiter's view (serves the masters, drives the Bridge)
//     master : the requesters'/Bridge model's view (the opposite directions)
// ----------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_we;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_we;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] s_addr;
  logic              s_we;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;

  modport slave (
    input  m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output s_addr, s_we, s_wdata,
    input  s_rdata
  );

  modport master (
    output m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  s_addr, s_we, s_wdata,
    output s_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Two-master round-robin arbiter in front of the Bridge slave bus. Master 0
//   is the CPU data port, master 1 a secondary requester (DMA/debug loader).
//   One single-beat transaction is issued per grant; read data is registered
//   and returned to the winning master one cycle after its grant.
//
//   Parameters:
//     ADDR_W   : address width
//     DATA_W   : data width
//     LOCK_MAX : max consecutive locked grants per owner (ARB_LOCK_EN only)
//   Ports:
//     clk      : single clock, rising edge
//     rst_n    : asynchronous active-low reset
//     bus      : bus_arbiter_if.slave (master channels + Bridge bus)
//
//   Build option: define ARB_LOCK_EN to honour m0_lock/m1_lock. When it is
//   undefined the lock inputs are ignored and arbitration is pure
//   round-robin with no lock counter.
// ----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  typedef enum logic {
    PRIO_M0 = 1'b0,
    PRIO_M1 = 1'b1
  } prio_t;

  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("bus_arbiter: LOCK_MAX must be at least 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  prio_t             r_prio;
  prio_t             w_prio_eff;

  logic              w_gnt0;
  logic              w_gnt1;
  logic [ADDR_W-1:0] w_s_addr;
  logic [DATA_W-1:0] w_s_wdata;
  logic              w_s_we;

  logic              r_m0_rvalid;
  logic [DATA_W-1:0] r_m0_rdata;
  logic              r_m1_rvalid;
  logic [DATA_W-1:0] r_m1_rdata;

`ifdef ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_KEEP = CNT_W'(LOCK_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LOCK_MAX);

  logic [CNT_W-1:0] r_lock_cnt;
  logic             w_keep0;
  logic             w_keep1;

  // Ownership is retained only while this grant is not yet the LOCK_MAX-th
  // consecutive locked one; after that normal round-robin takes over.
  assign w_keep0 = w_gnt0 & bus.m0_lock & (r_lock_cnt < CNT_KEEP);
  assign w_keep1 = w_gnt1 & bus.m1_lock & (r_lock_cnt < CNT_KEEP);
`endif

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt0      = bus.m0_req & (r_state == OWN0);
    w_gnt1      = bus.m1_req & (r_state == OWN1);

    // A grant this cycle hands priority to the other master immediately, so
    // the arbitration running in the same cycle already sees the new order.
    w_prio_eff  = r_prio;
    if (w_gnt0) begin
      w_prio_eff = PRIO_M1;
    end else if (w_gnt1) begin
      w_prio_eff = PRIO_M0;
    end

    w_state_nxt = IDLE;
    if (bus.m0_req && bus.m1_req) begin
      w_state_nxt = (w_prio_eff == PRIO_M0) ? OWN0 : OWN1;
    end else if (bus.m0_req) begin
      w_state_nxt = OWN0;
    end else if (bus.m1_req) begin
      w_state_nxt = OWN1;
    end

`ifdef ARB_LOCK_EN
    if (w_keep0) begin
      w_state_nxt = OWN0;
    end else if (w_keep1) begin
      w_state_nxt = OWN1;
    end
`endif

    w_s_addr  = '0;
    w_s_wdata = '0;
    case (r_state)
      OWN0: begin
        w_s_addr  = bus.m0_addr;
        w_s_wdata = bus.m0_wdata;
      end
      OWN1: begin
        w_s_addr  = bus.m1_addr;
        w_s_wdata = bus.m1_wdata;
      end
      default: begin
        w_s_addr  = '0;
        w_s_wdata = '0;
      end
    endcase

    // Gated by the grant, so an async reset (state -> IDLE) drops s_we at once.
    w_s_we = (bus.m0_we & w_gnt0) | (bus.m1_we & w_gnt1);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prio  <= PRIO_M0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_eff;
    end
  end

  // --------------------------------------------------------------------------
  // Read-data capture: each master's rdata only updates on its own grant.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rvalid <= 1'b0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_gnt0;
      r_m1_rvalid <= w_gnt1;
      if (w_gnt0) begin
        r_m0_rdata <= bus.s_rdata;
      end
      if (w_gnt1) begin
        r_m1_rdata <= bus.s_rdata;
      end
    end
  end

`ifdef ARB_LOCK_EN
  // --------------------------------------------------------------------------
  // Consecutive locked-grant counter. Clears when ownership moves (including
  // to IDLE) or on an unlocked grant; saturates at LOCK_MAX.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_lock_cnt <= '0;
    end else if ((w_gnt0 && bus.m0_lock) || (w_gnt1 && bus.m1_lock)) begin
      if (r_lock_cnt < CNT_SAT) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
    end else if (w_gnt0 || w_gnt1) begin
      r_lock_cnt <= '0;
    end
  end
`endif

  assign bus.m0_gnt    = w_gnt0;
  assign bus.m1_gnt    = w_gnt1;
  assign bus.m0_rvalid = r_m0_rvalid;
  assign bus.m0_rdata  = r_m0_rdata;
  assign bus.m1_rvalid = r_m1_rvalid;
  assign bus.m1_rdata  = r_m1_rdata;
  assign bus.s_addr    = w_s_addr;
  assign bus.s_we      = w_s_we;
  assign bus.s_wdata   = w_s_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed self-checking bench for bus_arbiter. Inputs are driven on the
//   falling edge; outputs are sampled 1 time unit later, well away from the
//   rising (active) edge. Build with or without ARB_LOCK_EN; the lock
//   scenario's expectations follow the macro.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .LOCK_MAX(8)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_req = 1'b0; bus.m0_lock = 1'b0; bus.m0_addr = '0; bus.m0_we = 1'b0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = '0; bus.m1_we = 1'b0; bus.m1_wdata = '0;
  endtask

  task automatic do_reset();
    cyc();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    bus.s_rdata = 32'hDEADBEEF;

    // ---------------- Reset state ----------------
    #2;
    check("rst_gnt",    {62'd0, bus.m0_gnt, bus.m1_gnt}, 64'd0);
    check("rst_rvalid", {62'd0, bus.m0_rvalid, bus.m1_rvalid}, 64'd0);
    check("rst_rdata",  {bus.m0_rdata, bus.m1_rdata}, 64'd0);
    check("rst_s_bus",  {bus.s_addr, bus.s_wdata}, 64'd0);
    check("rst_s_we",   {63'd0, bus.s_we}, 64'd0);
    cyc();
    rst_n = 1'b1;

    // ---------------- 1: m0 read, latency ----------------
    cyc(); bus.m0_req = 1'b1; bus.m0_addr = 32'h10; bus.m0_we = 1'b0; settle();
    check("t1_N_gnt0", {63'd0, bus.m0_gnt}, 64'd0);
    cyc(); settle();
    check("t1_N1_gnt0",   {63'd0, bus.m0_gnt}, 64'd1);
    check("t1_N1_saddr",  {32'd0, bus.s_addr}, 64'h10);
    check("t1_N1_swe",    {63'd0, bus.s_we}, 64'd0);
    check("t1_N1_rvalid", {63'd0, bus.m0_rvalid}, 64'd0);
    cyc(); bus.m0_req = 1'b0; settle();
    check("t1_N2_rvalid", {63'd0, bus.m0_rvalid}, 64'd1);
    check("t1_N2_rdata",  {32'd0, bus.m0_rdata}, 64'hDEADBEEF);
    check("t1_N2_gnt0",   {63'd0, bus.m0_gnt}, 64'd0);
    check("t1_N2_rv1",    {63'd0, bus.m1_rvalid}, 64'd0);
    cyc(); settle();
    check("t1_N3_rvalid", {63'd0, bus.m0_rvalid}, 64'd0);

    // ---------------- 2: both request -> alternation ----------------
    do_reset();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1; settle();
    check("t2_idle_gnts", {62'd0, bus.m0_gnt, bus.m1_gnt}, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc(); settle();
      // odd cycles -> M0 only (2'b10), even cycles -> M1 only (2'b01)
      check($sformatf("t2_gnt_c%0d", k), {62'd0, bus.m0_gnt, bus.m1_gnt},
            (k % 2 == 1) ? 64'd2 : 64'd1);
    end
    cyc(); bus.m0_req = 1'b0; bus.m1_req = 1'b0; settle();
    check("t2_drop_gnts", {62'd0, bus.m0_gnt, bus.m1_gnt}, 64'd0);
    cyc(); // now IDLE, prio = M0

    // ---------------- 3: m1 write ----------------
    bus.s_rdata = 32'hCAFE0001;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'hFFFFF000; bus.m1_wdata = 32'h12345678;
    settle();
    check("t3_pre_swe",  {63'd0, bus.s_we}, 64'd0);
    check("t3_pre_gnt1", {63'd0, bus.m1_gnt}, 64'd0);
    cyc(); settle();
    check("t3_gnt1",   {63'd0, bus.m1_gnt}, 64'd1);
    check("t3_swe",    {63'd0, bus.s_we}, 64'd1);
    check("t3_saddr",  {32'd0, bus.s_addr}, 64'hFFFFF000);
    check("t3_swdata", {32'd0, bus.s_wdata}, 64'h12345678);
    cyc(); bus.m1_req = 1'b0; settle();
    check("t3_post_swe", {63'd0, bus.s_we}, 64'd0);
    check("t3_rvalid1",  {63'd0, bus.m1_rvalid}, 64'd1);
    check("t3_rdata1",   {32'd0, bus.m1_rdata}, 64'hCAFE0001);
    check("t3_rdata0_hold", {32'd0, bus.m0_rdata}, 64'hDEADBEEF);
    cyc(); bus.m1_we = 1'b0; settle(); // IDLE, prio = M0

    // ---------------- 4: m0 drops req in its OWN0 cycle ----------------
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h20; bus.m0_wdata = 32'h55;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h30;
    cyc(); bus.m0_req = 1'b0; settle();
    check("t4_own0_gnts", {62'd0, bus.m0_gnt, bus.m1_gnt}, 64'd0);
    check("t4_own0_swe",  {63'd0, bus.s_we}, 64'd0);
    check("t4_own0_addr", {32'd0, bus.s_addr}, 64'h20);
    cyc(); settle();
    check("t4_gnt1",    {62'd0, bus.m0_gnt, bus.m1_gnt}, 64'd1);
    check("t4_saddr",   {32'd0, bus.s_addr}, 64'h30);
    check("t4_rvalid0", {63'd0, bus.m0_rvalid}, 64'd0);
    cyc(); bus.m1_req = 1'b0; bus.m0_we = 1'b0; settle();
    check("t4_rvalid0_b", {63'd0, bus.m0_rvalid}, 64'd0);
    cyc();

    // ---------------- 5: reset during m1 write beat ----------------
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h44; bus.m1_wdata = 32'h99;
    cyc(); settle();
    check("t5_beat_swe", {63'd0, bus.s_we}, 64'd1);
    rst_n = 1'b0; settle();
    check("t5_rst_swe",   {63'd0, bus.s_we}, 64'd0);
    check("t5_rst_gnts",  {62'd0, bus.m0_gnt, bus.m1_gnt}, 64'd0);
    check("t5_rst_sbus",  {bus.s_addr, bus.s_wdata}, 64'd0);
    check("t5_rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 64'd0);
    check("t5_rst_rv",    {62'd0, bus.m0_rvalid, bus.m1_rvalid}, 64'd0);
    cyc(); bus.m0_req = 1'b1; bus.m0_we = 1'b0; rst_n = 1'b1; settle();
    check("t5_rel_gnts", {62'd0, bus.m0_gnt, bus.m1_gnt}, 64'd0);
    cyc(); settle();
    check("t5_first_gnt", {62'd0, bus.m0_gnt, bus.m1_gnt}, 64'd2);

    // ---------------- 6: lock behaviour ----------------
    do_reset();
    bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m1_req = 1'b1; settle();
    for (int k = 1; k <= 10; k++) begin
      logic [63:0] exp_g;
      cyc(); settle();
`ifdef ARB_LOCK_EN
      // 8 locked M0 grants, then M1, then M0 again (counter cleared)
      exp_g = (k <= 8) ? 64'd2 : ((k == 9) ? 64'd1 : 64'd2);
`else
      exp_g = (k % 2 == 1) ? 64'd2 : 64'd1;
`endif
      check($sformatf("t6_gnt_c%0d", k), {62'd0, bus.m0_gnt, bus.m1_gnt}, exp_g);
    end
    cyc(); clear_inputs();
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
